// File: rtl/miss_msg_det_mch_pkg.sv
// miss_pkg: shared types for the multi-channel MoldUDP64 miss detector.
//   ch_state_e   : per-channel sync state
//   MISS_SEQ/SID : miss entry type codes
//   miss_entry_t : one retransmission-request FIFO entry
// The entry field widths below must match the top-level CH_W/SID_W/SEQ_NUM_W.
package miss_pkg;
  localparam int MISS_CH_W  = 1;
  localparam int MISS_SID_W = 80;
  localparam int MISS_SEQ_W = 64;

  typedef enum logic [1:0] {UNSYNC, SYNC, ENDED} ch_state_e;

  localparam logic MISS_SEQ = 1'b0;  // sequence gap inside one session
  localparam logic MISS_SID = 1'b1;  // one or more sessions skipped

  typedef struct packed {
    logic                  mtype;
    logic [MISS_CH_W-1:0]  ch;
    logic [MISS_SID_W-1:0] sid;
    logic [MISS_SEQ_W-1:0] seq_start;
    logic [MISS_SEQ_W-1:0] cnt;
  } miss_entry_t;
endpackage

// File: rtl/miss_msg_det_mch_if.sv
// Packet-header input bus plus miss-request output handshake.
//   master : header source / miss consumer (drives v_i..eos_i, miss_ready_i)
//   slave  : the detector
interface miss_msg_det_mch_if #(
  parameter int CH_W      = 1,
  parameter int SID_W     = 80,
  parameter int SEQ_NUM_W = 64,
  parameter int ML_W      = 16
);
  logic                 v_i;
  logic [CH_W-1:0]      ch_i;
  logic [SID_W-1:0]     sid_i;
  logic [SEQ_NUM_W-1:0] seq_num_i;
  logic [ML_W-1:0]      msg_cnt_i;
  logic                 eos_i;
  logic                 miss_v_o;
  logic                 miss_ready_i;
  logic                 miss_type_o;
  logic [CH_W-1:0]      miss_ch_o;
  logic [SID_W-1:0]     miss_sid_o;
  logic [SEQ_NUM_W-1:0] miss_seq_start_o;
  logic [SEQ_NUM_W-1:0] miss_cnt_o;

  modport master (
    output v_i, ch_i, sid_i, seq_num_i, msg_cnt_i, eos_i, miss_ready_i,
    input  miss_v_o, miss_type_o, miss_ch_o, miss_sid_o, miss_seq_start_o, miss_cnt_o
  );
  modport slave (
    input  v_i, ch_i, sid_i, seq_num_i, msg_cnt_i, eos_i, miss_ready_i,
    output miss_v_o, miss_type_o, miss_ch_o, miss_sid_o, miss_seq_start_o, miss_cnt_o
  );
endinterface

// File: rtl/miss_msg_det_mch_fifo.sv
// miss_req_fifo: synchronous FIFO of miss entries.
//   push_i/din_i : write (dropped when full and not popping same cycle)
//   pop_i        : pop head (ignored when empty)
//   valid_o/dout_o : head; dout_o is zero while empty
//   ovf_o        : sticky, set when a push was dropped; cleared by reset only
module miss_req_fifo
  import miss_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  miss_entry_t din_i,
  input  logic        pop_i,
  output logic        valid_o,
  output miss_entry_t dout_o,
  output logic        ovf_o
);
  localparam int AW = $clog2(DEPTH);

  miss_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, push_ok, pop_ok;

  always_comb begin
    full    = cnt_q == (AW+1)'(DEPTH);
    empty   = cnt_q == '0;
    pop_ok  = pop_i && !empty;
    // a pop frees the slot in the same cycle, so full+push+pop loses nothing
    push_ok = push_i && (!full || pop_ok);
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    ovf_d   = ovf_q || (push_i && !push_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  assign valid_o = !empty;
  assign dout_o  = empty ? '0 : mem_q[rd_q];
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/miss_msg_det_mch.sv
// miss_msg_det_mch: per-channel MoldUDP64 gap/duplicate detector.
//   clk, reset : clock, synchronous active-high reset
//   bus        : header input (v_i, ch_i, sid_i, seq_num_i, msg_cnt_i, eos_i)
//                and miss FIFO head (miss_v_o/miss_ready_i + entry fields)
//   dup_v_o/dup_ch_o : 1-cycle duplicate/late packet pulse and its channel
//   sid_err_o  : 1-cycle pulse on backward or oversized session jump
//   miss_ovf_o : sticky, a miss entry was dropped on a full FIFO
module miss_msg_det_mch
  import miss_pkg::*;
#(
  parameter int          CH_N        = 2,
  parameter int          CH_W        = (CH_N > 1) ? $clog2(CH_N) : 1,
  parameter int          SEQ_NUM_W   = MISS_SEQ_W,
  parameter int          SID_W       = MISS_SID_W,
  parameter int          ML_W        = 16,
  parameter int unsigned SID_GAP_MAX = 1 << 16,
  parameter int          FIFO_D      = 4
) (
  input  logic            clk,
  input  logic            reset,
  miss_msg_det_mch_if.slave bus,
  output logic            dup_v_o,
  output logic [CH_W-1:0] dup_ch_o,
  output logic            sid_err_o,
  output logic            miss_ovf_o
);
  ch_state_e            state_q [CH_N], state_d [CH_N];
  logic [SEQ_NUM_W-1:0] seq_q [CH_N], seq_d [CH_N];
  logic [SID_W-1:0]     sid_q [CH_N], sid_d [CH_N];
  logic                 dup_v_q, dup_v_d, sid_err_q, sid_err_d;
  logic [CH_W-1:0]      dup_ch_q, dup_ch_d;

  ch_state_e            cur_st, nxt_st;
  logic [SEQ_NUM_W-1:0] cur_seq, nxt_seq, e_eff, s, sn, seq_rule;
  logic [SID_W-1:0]     cur_sid, nxt_sid;
  logic [SID_W:0]       d;
  logic                 ch_ok, hit, gap, lag, too_far, push;
  logic [SEQ_NUM_W-1:0] sid_cnt;
  miss_entry_t          push_e, head;

  // select the addressed channel's state
  always_comb begin
    cur_st  = UNSYNC;
    cur_seq = '0;
    cur_sid = '0;
    for (int i = 0; i < CH_N; i++) begin
      if (bus.ch_i == CH_W'(i)) begin
        cur_st  = state_q[i];
        cur_seq = seq_q[i];
        cur_sid = sid_q[i];
      end
    end
  end

  always_comb begin
    ch_ok    = {1'b0, bus.ch_i} < (CH_W+1)'(CH_N);
    hit      = bus.v_i && ch_ok;
    s        = bus.seq_num_i;
    sn       = s + SEQ_NUM_W'(bus.msg_cnt_i);
    // a session opened from ENDED starts counting at 0
    e_eff    = (cur_st == SYNC) ? cur_seq : '0;
    gap      = s > e_eff;
    lag      = s < e_eff;
    seq_rule = (lag && sn <= e_eff) ? e_eff : sn;
    // one extra bit: MSB set means the session went backward
    d        = {1'b0, bus.sid_i} - {1'b0, cur_sid};
    too_far  = d[SID_W] || d > (SID_W+1)'(SID_GAP_MAX);
    sid_cnt  = (|d[SID_W:SEQ_NUM_W]) ? '1 : d[SEQ_NUM_W-1:0];

    nxt_st    = cur_st;
    nxt_seq   = cur_seq;
    nxt_sid   = cur_sid;
    push      = 1'b0;
    push_e    = '0;
    push_e.ch = MISS_CH_W'(bus.ch_i);
    dup_v_d   = 1'b0;
    dup_ch_d  = '0;
    sid_err_d = 1'b0;

    if (hit) begin
      if (cur_st == UNSYNC) begin
        nxt_sid = bus.sid_i;
        nxt_seq = sn;
        nxt_st  = bus.eos_i ? ENDED : SYNC;
      end else if (bus.sid_i == cur_sid) begin
        if (cur_st == ENDED) begin
          dup_v_d = 1'b1;  // stale retransmit of a closed session
        end else begin
          push             = gap;
          push_e.mtype     = MISS_SEQ;
          push_e.sid       = cur_sid;
          push_e.seq_start = e_eff;
          push_e.cnt       = s - e_eff;
          dup_v_d          = lag;
          nxt_seq          = seq_rule;
          if (bus.eos_i) nxt_st = ENDED;
        end
      end else if (too_far) begin
        sid_err_d = 1'b1;
        nxt_st    = UNSYNC;
      end else if (cur_st == ENDED && d == (SID_W+1)'(1)) begin
        // clean rollover to the next session; seq rules run against 0
        push             = gap;
        push_e.mtype     = MISS_SEQ;
        push_e.sid       = bus.sid_i;
        push_e.seq_start = '0;
        push_e.cnt       = s;
        nxt_sid          = bus.sid_i;
        nxt_seq          = seq_rule;
        nxt_st           = bus.eos_i ? ENDED : SYNC;
      end else begin
        push             = 1'b1;
        push_e.mtype     = MISS_SID;
        push_e.sid       = cur_sid;
        push_e.seq_start = cur_seq;
        push_e.cnt       = sid_cnt;
        nxt_sid          = bus.sid_i;
        nxt_seq          = sn;
        nxt_st           = bus.eos_i ? ENDED : SYNC;
      end
      if (dup_v_d) dup_ch_d = bus.ch_i;
    end

    state_d = state_q;
    seq_d   = seq_q;
    sid_d   = sid_q;
    for (int i = 0; i < CH_N; i++) begin
      if (hit && bus.ch_i == CH_W'(i)) begin
        state_d[i] = nxt_st;
        seq_d[i]   = nxt_seq;
        sid_d[i]   = nxt_sid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '{default: UNSYNC};
      seq_q     <= '{default: '0};
      sid_q     <= '{default: '0};
      dup_v_q   <= 1'b0;
      dup_ch_q  <= '0;
      sid_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      sid_q     <= sid_d;
      dup_v_q   <= dup_v_d;
      dup_ch_q  <= dup_ch_d;
      sid_err_q <= sid_err_d;
    end
  end

  miss_req_fifo #(.DEPTH(FIFO_D)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_e),
    .pop_i   (bus.miss_ready_i),
    .valid_o (bus.miss_v_o),
    .dout_o  (head),
    .ovf_o   (miss_ovf_o)
  );

  assign bus.miss_type_o      = head.mtype;
  assign bus.miss_ch_o        = CH_W'(head.ch);
  assign bus.miss_sid_o       = SID_W'(head.sid);
  assign bus.miss_seq_start_o = SEQ_NUM_W'(head.seq_start);
  assign bus.miss_cnt_o       = SEQ_NUM_W'(head.cnt);
  assign dup_v_o              = dup_v_q;
  assign dup_ch_o             = dup_ch_q;
  assign sid_err_o            = sid_err_q;
endmodule

// File: tb/tb_miss_msg_det_mch.sv
module tb_miss_msg_det_mch;
  logic clk = 1'b0;
  logic reset;
  logic dup_v_o, sid_err_o, miss_ovf_o;
  logic [0:0] dup_ch_o;
  int checks = 0;
  int errors = 0;

  miss_msg_det_mch_if #(.CH_W(1), .SID_W(80), .SEQ_NUM_W(64), .ML_W(16)) bus ();

  miss_msg_det_mch dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dup_v_o    (dup_v_o),
    .dup_ch_o   (dup_ch_o),
    .sid_err_o  (sid_err_o),
    .miss_ovf_o (miss_ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one header for one cycle; returns #1 after the sampling edge
  task automatic send(input int ch, input logic [79:0] sid, input logic [63:0] seq,
                      input int cnt, input bit eos, input bit rdy);
    bus.v_i          = 1'b1;
    bus.ch_i         = 1'(ch);
    bus.sid_i        = sid;
    bus.seq_num_i    = seq;
    bus.msg_cnt_i    = 16'(cnt);
    bus.eos_i        = eos;
    bus.miss_ready_i = rdy;
    @(posedge clk);
    #1;
    bus.v_i          = 1'b0;
    bus.eos_i        = 1'b0;
    bus.miss_ready_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input bit typ, input int ch,
                         input logic [79:0] sid, input logic [63:0] start, input logic [63:0] cnt);
    chk({tag, ".v"}, 128'(bus.miss_v_o), 128'(1));
    chk({tag, ".type"}, 128'(bus.miss_type_o), 128'(typ));
    chk({tag, ".ch"}, 128'(bus.miss_ch_o), 128'(ch));
    chk({tag, ".sid"}, 128'(bus.miss_sid_o), 128'(sid));
    chk({tag, ".start"}, 128'(bus.miss_seq_start_o), 128'(start));
    chk({tag, ".cnt"}, 128'(bus.miss_cnt_o), 128'(cnt));
    bus.miss_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.miss_ready_i = 1'b0;
  endtask

  task automatic quiet(input string tag, input bit dup, input bit err, input bit mv);
    chk({tag, ".dup"}, 128'(dup_v_o), 128'(dup));
    chk({tag, ".err"}, 128'(sid_err_o), 128'(err));
    chk({tag, ".mv"}, 128'(bus.miss_v_o), 128'(mv));
  endtask

  initial begin
    bus.v_i = 1'b0; bus.ch_i = '0; bus.sid_i = '0; bus.seq_num_i = '0;
    bus.msg_cnt_i = '0; bus.eos_i = 1'b0; bus.miss_ready_i = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    quiet("rst", 0, 0, 0);
    chk("rst.ovf", 128'(miss_ovf_o), 128'(0));
    reset = 1'b0;

    // in-order stream on ch0, then a sequence gap 8..19
    send(0, 3, 0, 5, 0, 0);   quiet("sync", 0, 0, 0);
    send(0, 3, 5, 3, 0, 0);   quiet("inorder", 0, 0, 0);
    send(0, 3, 20, 2, 0, 0);  quiet("gap0", 0, 0, 1);
    pop_chk("gap0", 0, 0, 3, 8, 12);

    // interleaved: gap only on ch1
    send(1, 9, 0, 4, 0, 0);   quiet("ch1sync", 0, 0, 0);
    send(0, 3, 22, 0, 0, 0);  quiet("ch0hb", 0, 0, 0);
    send(1, 9, 7, 1, 0, 0);   quiet("gap1", 0, 0, 1);
    pop_chk("gap1", 0, 1, 9, 4, 3);
    chk("gap1.empty", 128'(bus.miss_v_o), 128'(0));

    // duplicates: full and partial
    send(0, 3, 10, 5, 0, 0);  quiet("dupfull", 1, 0, 0);
    chk("dupfull.ch", 128'(dup_ch_o), 128'(0));
    send(0, 3, 20, 5, 0, 0);  quiet("duppart", 1, 0, 0);
    send(0, 3, 25, 1, 0, 0);  quiet("after_dup", 0, 0, 0);
    send(1, 9, 0, 2, 0, 0);   quiet("dupch1", 1, 0, 0);
    chk("dupch1.ch", 128'(dup_ch_o), 128'(1));

    // session handling on ch0 (seq_q=26)
    send(0, 3, 26, 0, 1, 0);  quiet("eos", 0, 0, 0);
    send(0, 3, 26, 1, 0, 0);  quiet("stale", 1, 0, 0);
    send(0, 4, 0, 2, 0, 0);   quiet("rollover", 0, 0, 0);
    send(0, 7, 0, 1, 0, 0);   quiet("sidgap", 0, 0, 1);
    pop_chk("sidgap", 1, 0, 4, 2, 3);
    send(0, 80'd7 + 80'd65537, 0, 1, 0, 0); quiet("sidfar", 0, 1, 0);
    send(0, 100, 50, 1, 0, 0); quiet("resync", 0, 0, 0);
    send(0, 50, 0, 1, 0, 0);  quiet("sidback", 0, 1, 0);

    // overflow on ch1 (seq_q=8), ready held low
    send(1, 9, 10, 0, 0, 0);
    send(1, 9, 13, 0, 0, 0);
    send(1, 9, 17, 0, 0, 0);
    send(1, 9, 22, 0, 0, 0);
    chk("full.ovf0", 128'(miss_ovf_o), 128'(0));
    send(1, 9, 28, 0, 0, 0);
    chk("full.ovf1", 128'(miss_ovf_o), 128'(1));
    // full + push + pop together: head 8/2 leaves, 28/7 enters
    send(1, 9, 35, 0, 0, 1);
    chk("pushpop.mv", 128'(bus.miss_v_o), 128'(1));
    pop_chk("drain0", 0, 1, 9, 10, 3);
    pop_chk("drain1", 0, 1, 9, 13, 4);
    pop_chk("drain2", 0, 1, 9, 17, 5);
    pop_chk("drain3", 0, 1, 9, 28, 7);
    chk("drained", 128'(bus.miss_v_o), 128'(0));
    bus.miss_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.miss_ready_i = 1'b0;
    chk("emptypop", 128'(bus.miss_v_o), 128'(0));
    chk("ovf.sticky", 128'(miss_ovf_o), 128'(1));

    // reset discards everything
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst2.ovf", 128'(miss_ovf_o), 128'(0));
    send(1, 500, 40, 1, 0, 0); quiet("rst2.unsync", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/miss_msg_det_mch.md
Name: miss_msg_det_mch

Overview:
Multi-channel successor to the single-feed MoldUDP64 miss detector. It tracks the expected session ID and sequence number independently for CH_N feeds arriving time-multiplexed on one bus. Each detected gap (sequence or session) becomes an entry in a shared retransmission-request FIFO, drained through a valid/ready handshake. Duplicate and late packets are flagged. Sits after the MoldUDP64 header parser, ahead of the retransmit-request builder.

Parameters:
CH_N, 2, number of independent feeds
CH_W, $clog2(CH_N) (min 1), channel index width
SEQ_NUM_W, 64, sequence number width
SID_W, 80, session ID width
ML_W, 16, message count width
SID_GAP_MAX, 1<<16, largest session jump accepted as a legal gap
FIFO_D, 4, miss-request FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
v_i  in  1  packet header valid (no backpressure)
ch_i  in  CH_W  channel index
sid_i  in  SID_W  session ID
seq_num_i  in  SEQ_NUM_W  first sequence number in packet
msg_cnt_i  in  ML_W  message count (0 = heartbeat)
eos_i  in  1  end-of-session packet
dup_v_o  out  1  packet fully/partly duplicate (1-cycle pulse)
dup_ch_o  out  CH_W  channel of dup_v_o
sid_err_o  out  1  session jump > SID_GAP_MAX or backward (1-cycle pulse)
miss_v_o  out  1  FIFO head valid
miss_ready_i  in  1  consumer accepts head
miss_type_o  out  1  0 = sequence gap, 1 = session gap
miss_ch_o  out  CH_W  channel
miss_sid_o  out  SID_W  session of the gap start
miss_seq_start_o  out  SEQ_NUM_W  first missing sequence number
miss_cnt_o  out  SEQ_NUM_W  missing messages (type 0) or skipped sessions, saturating (type 1)
miss_ovf_o  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset: every channel goes to UNSYNC, seq_q=0, sid_q=0. FIFO empty. All outputs 0.
- Per-channel FSM states: UNSYNC, SYNC, ENDED. Only the channel addressed by ch_i is updated. ch_i >= CH_N: packet ignored.
- UNSYNC + v_i: adopt sid_q=sid_i, seq_q=seq_num_i+msg_cnt_i. No event. Go to SYNC, or to ENDED if eos_i.
- SYNC, sid_i==sid_q, with E=seq_q, S=seq_num_i, N=msg_cnt_i:
  - S>E: push type 0 {sid_q, start=E, cnt=S-E}; seq_q=S+N.
  - S==E: seq_q=S+N.
  - S<E and S+N<=E: dup pulse; no update.
  - S<E and S+N>E: dup pulse; seq_q=S+N.
  - eos_i: apply the rules above, then go to ENDED.
- Session change (SYNC or ENDED), with D=sid_i-sid_q computed unsigned in SID_W+1 bits:
  - D==1 from ENDED: new session, seq_q=0, then the sequence rules above apply against E=0.
  - D>=1 from SYNC, or D>1 from ENDED:
    - push type 1 {sid=sid_q, start=seq_q, cnt=min(D, 2^SEQ_NUM_W-1)};
    - adopt as in UNSYNC.
  - D > SID_GAP_MAX or sid_i<sid_q: sid_err pulse, no push, channel goes to UNSYNC.
- ENDED with sid_i==sid_q: stale retransmit. Dup pulse, no update.
- Sequence arithmetic: modulo 2^SEQ_NUM_W. Zero-extend msg_cnt_i.
- Latency: state update and dup/sid_err pulses occur 1 cycle after v_i. A FIFO entry is visible (miss_v_o) 1 cycle after v_i. Back-to-back packets on the same channel see the updated state.
- At most one event per input packet.
- FIFO handshake: the head pops when miss_v_o & miss_ready_i. Head fields stay stable while miss_v_o=1 and not popped.
- Full FIFO + push + pop in the same cycle: both succeed.
- Full FIFO + push, no pop: entry dropped, miss_ovf_o set. Only reset clears it.
- Empty FIFO: pop is ignored.
- Reset mid-operation: all channel state and FIFO contents are discarded. No event is emitted.

Decomposition:
- Shared package miss_pkg:
  - channel state enum {UNSYNC, SYNC, ENDED}
  - miss_type constants
  - packed miss-entry struct {type, ch, sid, seq_start, cnt}
- Sub-module miss_req_fifo: generic synchronous FIFO of entry structs (FIFO_D, full/empty, sticky overflow).
- The top module holds the per-channel state arrays and the comparators.

Test Plan:
- Ch0 seq 0 cnt 5, then seq 5 cnt 3 -> no miss, no dup; ch0 seq_q=8.
- Ch0 synced at seq_q=8, packet seq 20 cnt 2 -> type-0 entry {ch0, start 8, cnt 12}; seq_q=22; miss_v_o high 1 cycle after v_i.
- Interleaved ch0/ch1 with a gap only on ch1 (ch1 seq_q=4, packet seq 7) -> single entry {ch1, start 4, cnt 3}; ch0 produces no events.
- Ch0 seq_q=22, packet seq 10 cnt 5 -> dup_v_o pulse; seq_q stays 22. Packet seq 20 cnt 5 -> dup pulse; seq_q=25.
- Ch0 eos in sid 3, next packet sid 4 seq 0 -> no event. Next packet sid 7 -> type-1 entry {sid 4, cnt 3}. Then sid 7+SID_GAP_MAX+1 -> sid_err pulse, channel UNSYNC.
- miss_ready_i held low, FIFO_D+1 gaps -> FIFO_D entries, miss_ovf_o=1. Release ready -> entries drain in order. Full + push + pop in the same cycle -> no loss.
